// File: rtl/list_sum_pkg.sv
// Shared types for the linked-list sum controller: state encoding, datapath
// control bundle, selector polarities and the per-state control decode.
package list_sum_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_RD_VAL = 3'd2,
        ST_ACC    = 3'd3,
        ST_RD_PTR = 3'd4,
        ST_LINK   = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } state_e;

    typedef struct packed {
        logic ld_sum;
        logic sum_sel;
        logic ld_next;
        logic next_sel;
        logic a_sel;
    } ctrl_t;

    localparam logic SUM_SEL_ADD  = 1'b1;
    localparam logic SUM_SEL_CLR  = 1'b0;
    localparam logic NEXT_SEL_RAM = 1'b1;
    localparam logic NEXT_SEL_CLR = 1'b0;
    localparam logic A_SEL_LINK   = 1'b1;
    localparam logic A_SEL_VAL    = 1'b0;

    localparam ctrl_t CTRL_NONE = ctrl_t'(5'b00000);

    // Moore decode: datapath controls depend on the state alone.
    function automatic ctrl_t decode_ctrl(input state_e s);
        ctrl_t c;
        c = CTRL_NONE;
        case (s)
            ST_INIT: begin
                c.ld_sum   = 1'b1;
                c.sum_sel  = SUM_SEL_CLR;
                c.ld_next  = 1'b1;
                c.next_sel = NEXT_SEL_CLR;
            end
            ST_RD_VAL: c.a_sel = A_SEL_VAL;
            ST_ACC: begin
                c.a_sel   = A_SEL_VAL;
                c.ld_sum  = 1'b1;
                c.sum_sel = SUM_SEL_ADD;
            end
            ST_RD_PTR: c.a_sel = A_SEL_LINK;
            ST_LINK: begin
                c.a_sel    = A_SEL_LINK;
                c.ld_next  = 1'b1;
                c.next_sel = NEXT_SEL_RAM;
            end
            default: c = CTRL_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/list_sum_ctrl_rd_wait_cnt.sv
// Loadable down-counter that holds the RAM address for the read latency;
// expires when it reaches zero and then rests there.
module rd_wait_cnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expired
);

    logic [W-1:0] r_cnt;

    // Count register: load on entry to a read state, else count down to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= {W{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != {W{1'b0}}) begin
            r_cnt <= r_cnt - W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expired = (r_cnt == {W{1'b0}});

endmodule

// File: rtl/list_sum_ctrl.sv
// Moore controller sequencing the datapath through a linked-list sum with
// start/done handshake, abort, read-latency wait and runaway-list detection.
module list_sum_ctrl
    import list_sum_pkg::*;
#(
    parameter int RD_LAT    = 1,
    parameter int MAX_NODES = 255,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             next_zero,
    output logic             ld_sum,
    output logic             sum_sel,
    output logic             ld_next,
    output logic             next_sel,
    output logic             a_sel,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] node_cnt
);

    localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_e           r_state;
    state_e           w_state_seq;
    state_e           w_state_nxt;
    ctrl_t            r_ctrl;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [CNT_W-1:0] r_node_cnt;
    logic             w_wait_load;
    logic             w_wait_exp;
    logic             w_accept;
    logic             w_count;
    logic             w_set_err;

    rd_wait_cnt #(
        .W (WAIT_W)
    ) u_rd_wait_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_wait_load),
        .i_load_val (WAIT_W'(RD_LAT - 1)),
        .o_expired  (w_wait_exp)
    );

    // Next-state logic; the wait counter is loaded on every entry to a read state.
    always_comb begin
        w_state_seq = r_state;
        w_wait_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_seq = ST_INIT;
                end else begin
                    w_state_seq = ST_IDLE;
                end
            end
            ST_INIT: begin
                w_state_seq = ST_RD_VAL;
                w_wait_load = 1'b1;
            end
            ST_RD_VAL: begin
                if (w_wait_exp) begin
                    w_state_seq = ST_ACC;
                end else begin
                    w_state_seq = ST_RD_VAL;
                end
            end
            ST_ACC: begin
                w_state_seq = ST_RD_PTR;
                w_wait_load = 1'b1;
            end
            ST_RD_PTR: begin
                if (w_wait_exp) begin
                    w_state_seq = ST_LINK;
                end else begin
                    w_state_seq = ST_RD_PTR;
                end
            end
            ST_LINK: begin
                if (next_zero) begin
                    w_state_seq = ST_DONE;
                end else if (r_node_cnt == CNT_W'(MAX_NODES)) begin
                    w_state_seq = ST_ERR;
                end else begin
                    w_state_seq = ST_RD_VAL;
                    w_wait_load = 1'b1;
                end
            end
            ST_DONE: w_state_seq = ST_IDLE;
            ST_ERR:  w_state_seq = ST_IDLE;
            default: w_state_seq = ST_IDLE;
        endcase
    end

    // Abort overrides every transition except from IDLE, where it has no effect.
    assign w_state_nxt = (abort && (r_state != ST_IDLE)) ? ST_IDLE : w_state_seq;
    assign w_accept    = (r_state == ST_IDLE) && start;
    assign w_count     = (r_state == ST_ACC) && !abort;
    assign w_set_err   = (r_state == ST_ERR) && !abort;

    // State register; outputs are registered from the decode of the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ctrl  <= CTRL_NONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ctrl  <= decode_ctrl(w_state_nxt);
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= (w_state_nxt == ST_DONE) || (w_state_nxt == ST_ERR);
        end
    end

    // Run statistics: node count and sticky error, both cleared on accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_node_cnt <= {CNT_W{1'b0}};
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_node_cnt <= {CNT_W{1'b0}};
            r_err      <= 1'b0;
        end else begin
            r_node_cnt <= w_count ? (r_node_cnt + CNT_W'(1)) : r_node_cnt;
            r_err      <= w_set_err ? 1'b1 : r_err;
        end
    end

    assign ld_sum   = r_ctrl.ld_sum;
    assign sum_sel  = r_ctrl.sum_sel;
    assign ld_next  = r_ctrl.ld_next;
    assign next_sel = r_ctrl.next_sel;
    assign a_sel    = r_ctrl.a_sel;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign node_cnt = r_node_cnt;

endmodule
